// File: rtl/stage_w_hs.sv
`default_nettype none
// ============================================================================
//  Module   : stage_w_hs
//  Purpose  : Writeback stage for the combined ARM/RV core. A single-entry
//             M->W pipeline register with a valid/ready handshake, an N-way
//             result mux and a wait for variable-latency load data. Stage_m
//             is held off while a load waits for its data.
//  Ports    : clk, rst (async, active-low)
//             M side : arm, ValidM, ReadyW, ALUResultM, PCPlus4M, ExtResultM,
//                      RdM, PCSrcM, RegWriteM, ResultSrcM
//             memory : ReadDataW, ReadValidW
//             W side : ValidW, RdW, ResultW, RegWriteW, PCSrcW, ProtoErrW
//  Revision : 1.0  initial release
// ============================================================================
module stage_w_hs #(
  parameter  int XLEN = 32,
  parameter  int REGW = 5,
  parameter  int NEXT = 1,
  localparam int SRCW = $clog2(NEXT + 3)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 arm,
  input  logic                 ValidM,
  output logic                 ReadyW,
  input  logic [XLEN-1:0]      ALUResultM,
  input  logic [XLEN-1:0]      PCPlus4M,
  input  logic [NEXT*XLEN-1:0] ExtResultM,
  input  logic [REGW-1:0]      RdM,
  input  logic                 PCSrcM,
  input  logic                 RegWriteM,
  input  logic [SRCW-1:0]      ResultSrcM,
  input  logic [XLEN-1:0]      ReadDataW,
  input  logic                 ReadValidW,
  output logic                 ValidW,
  output logic [REGW-1:0]      RdW,
  output logic [XLEN-1:0]      ResultW,
  output logic                 RegWriteW,
  output logic                 PCSrcW,
  output logic                 ProtoErrW
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ALU   = 2'd1,
    S_WAIT  = 2'd2,
    S_LDONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [XLEN-1:0]      alu_q;
  logic [XLEN-1:0]      pc4_q;
  logic [NEXT*XLEN-1:0] ext_q;
  logic [XLEN-1:0]      load_q;
  logic [REGW-1:0]      rd_q;
  logic                 pcsrc_q;
  logic                 regwrite_q;
  logic [SRCW-1:0]      src_q;
  logic                 arm_q;
  logic                 proto_err_q;

  logic accept;
  logic load_arrive;

  assign ReadyW      = (state_q != S_WAIT);
  assign accept      = ValidM & ReadyW;
  assign load_arrive = (state_q == S_WAIT) & ReadValidW;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A completed entry (ALU/LDONE) is either replaced by a
  // newly accepted instruction or drained back to EMPTY in the same cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY, S_ALU, S_LDONE: begin
        if (accept) begin
          state_d = (ResultSrcM == '0) ? S_WAIT : S_ALU;
        end else begin
          state_d = S_EMPTY;
        end
      end
      S_WAIT: begin
        if (ReadValidW) begin
          state_d = S_LDONE;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Instruction payload, load data and the sticky protocol flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_q       <= '0;
      pc4_q       <= '0;
      ext_q       <= '0;
      load_q      <= '0;
      rd_q        <= '0;
      pcsrc_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      src_q       <= '0;
      arm_q       <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (accept) begin
        alu_q      <= ALUResultM;
        pc4_q      <= PCPlus4M;
        ext_q      <= ExtResultM;
        rd_q       <= RdM;
        pcsrc_q    <= PCSrcM;
        regwrite_q <= RegWriteM;
        src_q      <= ResultSrcM;
        arm_q      <= arm;
      end
      if (load_arrive) begin
        load_q <= ReadDataW;
      end
      // Data strobes outside WAIT (including the accept cycle of a load)
      // are never consumed and are flagged.
      if (ReadValidW && (state_q != S_WAIT)) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  // Result mux; unknown selects fall back to the ALU result.
  always_comb begin
    ResultW = alu_q;
    if (src_q == SRCW'(0)) begin
      ResultW = load_q;
    end else if (src_q == SRCW'(1)) begin
      // ARM has no PC+4 writeback; the ALU already holds the link value.
      ResultW = arm_q ? alu_q : pc4_q;
    end else begin
      for (int i = 0; i < NEXT; i++) begin
        if (src_q == SRCW'(i + 3)) begin
          ResultW = ext_q[i*XLEN +: XLEN];
        end
      end
    end
  end

  assign ValidW    = (state_q == S_ALU) | (state_q == S_LDONE);
  assign RdW       = rd_q;
  // RV x0 is hard-wired zero; ARM R0 is an ordinary register.
  assign RegWriteW = ValidW & regwrite_q & ~(~arm_q & (rd_q == '0));
  assign PCSrcW    = ValidW & pcsrc_q & arm_q;
  assign ProtoErrW = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_w_hs.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stage_w_hs
//  Purpose  : Self-checking bench for stage_w_hs (NEXT=2). A transaction
//             level model predicts each completion from the accepted
//             instruction; directed sequences pin literal values, then a
//             randomized run is compared every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_stage_w_hs;

  localparam int XLEN = 32;
  localparam int REGW = 5;
  localparam int NEXT = 2;
  localparam int SRCW = $clog2(NEXT + 3);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 arm;
  logic                 ValidM;
  logic                 ReadyW;
  logic [XLEN-1:0]      ALUResultM;
  logic [XLEN-1:0]      PCPlus4M;
  logic [NEXT*XLEN-1:0] ExtResultM;
  logic [REGW-1:0]      RdM;
  logic                 PCSrcM;
  logic                 RegWriteM;
  logic [SRCW-1:0]      ResultSrcM;
  logic [XLEN-1:0]      ReadDataW;
  logic                 ReadValidW;
  logic                 ValidW;
  logic [REGW-1:0]      RdW;
  logic [XLEN-1:0]      ResultW;
  logic                 RegWriteW;
  logic                 PCSrcW;
  logic                 ProtoErrW;

  int n_checks = 0;
  int n_err    = 0;
  bit check_en = 1'b0;

  stage_w_hs #(.XLEN(XLEN), .REGW(REGW), .NEXT(NEXT)) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .ValidM     (ValidM),
    .ReadyW     (ReadyW),
    .ALUResultM (ALUResultM),
    .PCPlus4M   (PCPlus4M),
    .ExtResultM (ExtResultM),
    .RdM        (RdM),
    .PCSrcM     (PCSrcM),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .ReadDataW  (ReadDataW),
    .ReadValidW (ReadValidW),
    .ValidW     (ValidW),
    .RdW        (RdW),
    .ResultW    (ResultW),
    .RegWriteW  (RegWriteW),
    .PCSrcW     (PCSrcW),
    .ProtoErrW  (ProtoErrW)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Transaction model: the expected writeback is computed when the
  // instruction is accepted; a load only gets its value when data arrives.
  // --------------------------------------------------------------------------
  bit              m_wait;   // a load is outstanding
  bit              m_valid;  // a completion is visible this cycle
  bit              m_perr;
  logic [31:0]     m_res;
  logic [REGW-1:0] m_rd;
  bit              m_we;
  bit              m_pc;

  function automatic logic [31:0] expect_result(input int src, input bit a,
                                                 input logic [31:0] alu,
                                                 input logic [31:0] pc4,
                                                 input logic [NEXT*XLEN-1:0] ext);
    logic [NEXT*XLEN-1:0] e;
    e = ext;
    if (src == 1) return a ? alu : pc4;
    if (src >= 3 && src <= NEXT + 2) return e[(src-3)*XLEN +: XLEN];
    return alu;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_wait  = 1'b0;
      m_valid = 1'b0;
      m_perr  = 1'b0;
      m_we    = 1'b0;
      m_pc    = 1'b0;
    end else begin
      if (ReadValidW && !m_wait) m_perr = 1'b1;
      if (m_wait) begin
        if (ReadValidW) begin
          m_res   = ReadDataW;
          m_wait  = 1'b0;
          m_valid = 1'b1;
        end
      end else if (ValidM) begin
        m_rd  = RdM;
        m_we  = RegWriteM && !(!arm && RdM == 0);
        m_pc  = PCSrcM && arm;
        if (ResultSrcM == 0) begin
          m_wait  = 1'b1;
          m_valid = 1'b0;
        end else begin
          m_res   = expect_result(int'(ResultSrcM), arm, ALUResultM, PCPlus4M, ExtResultM);
          m_valid = 1'b1;
        end
      end else begin
        m_valid = 1'b0;
      end
    end
  end

  // Cycle-by-cycle comparison away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("ReadyW",    {31'd0, ReadyW},    {31'd0, !m_wait});
      chk("ValidW",    {31'd0, ValidW},    {31'd0, m_valid});
      chk("RegWriteW", {31'd0, RegWriteW}, {31'd0, m_valid && m_we});
      chk("PCSrcW",    {31'd0, PCSrcW},    {31'd0, m_valid && m_pc});
      chk("ProtoErrW", {31'd0, ProtoErrW}, {31'd0, m_perr});
      if (m_valid) begin
        chk("RdW",     {27'd0, RdW}, {27'd0, m_rd});
        chk("ResultW", ResultW,      m_res);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ValidM     = 1'b0;
    ALUResultM = '0;
    PCPlus4M   = '0;
    ExtResultM = '0;
    RdM        = '0;
    PCSrcM     = 1'b0;
    RegWriteM  = 1'b0;
    ResultSrcM = '0;
    ReadDataW  = '0;
    ReadValidW = 1'b0;
  endtask

  task automatic issue(input bit a, input int src, input logic [31:0] alu,
                       input logic [4:0] rd, input bit rw, input bit pcs);
    ValidM     = 1'b1;
    arm        = a;
    ResultSrcM = SRCW'(src);
    ALUResultM = alu;
    RdM        = rd;
    RegWriteM  = rw;
    PCSrcM     = pcs;
  endtask

  initial begin
    rst = 1'b0;
    arm = 1'b1;
    idle_inputs();
    tick();
    tick();
    // Reset values
    chk("rst ReadyW",    {31'd0, ReadyW},    32'd1);
    chk("rst ValidW",    {31'd0, ValidW},    32'd0);
    chk("rst RegWriteW", {31'd0, RegWriteW}, 32'd0);
    chk("rst ResultW",   ResultW,            32'd0);
    chk("rst ProtoErrW", {31'd0, ProtoErrW}, 32'd0);
    rst = 1'b1;
    check_en = 1'b1;
    tick();

    // Back-to-back ALU results
    issue(1'b1, 2, 32'h11, 5'd5, 1'b1, 1'b0);
    tick();
    chk("b2b0 we",  {31'd0, RegWriteW}, 32'd1);
    chk("b2b0 res", ResultW, 32'h11);
    chk("b2b0 rd",  {27'd0, RdW}, 32'd5);
    issue(1'b1, 2, 32'h22, 5'd6, 1'b1, 1'b0);
    tick();
    chk("b2b1 res", ResultW, 32'h22);
    chk("b2b1 rd",  {27'd0, RdW}, 32'd6);
    issue(1'b1, 2, 32'h33, 5'd7, 1'b1, 1'b0);
    tick();
    chk("b2b2 we",  {31'd0, RegWriteW}, 32'd1);
    chk("b2b2 res", ResultW, 32'h33);
    chk("b2b2 rd",  {27'd0, RdW}, 32'd7);
    ValidM = 1'b0;
    tick();
    chk("drain valid", {31'd0, ValidW}, 32'd0);

    // Load with 4-cycle data latency
    issue(1'b1, 0, 32'h5555, 5'd9, 1'b1, 1'b0);
    tick();
    ValidM = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("load ready", {31'd0, ReadyW}, 32'd0);
      tick();
    end
    ReadValidW = 1'b1;
    ReadDataW  = 32'hDEADBEEF;
    chk("load ready4", {31'd0, ReadyW}, 32'd0);
    tick();
    ReadValidW = 1'b0;
    chk("load we",  {31'd0, RegWriteW}, 32'd1);
    chk("load res", ResultW, 32'hDEADBEEF);
    chk("load rd",  {27'd0, RdW}, 32'd9);
    chk("load perr", {31'd0, ProtoErrW}, 32'd0);

    // RV x0 suppression vs ARM R0
    issue(1'b0, 2, 32'h1, 5'd0, 1'b1, 1'b0);
    tick();
    chk("rv x0 valid", {31'd0, ValidW}, 32'd1);
    chk("rv x0 we",    {31'd0, RegWriteW}, 32'd0);
    issue(1'b1, 2, 32'h1, 5'd0, 1'b1, 1'b0);
    tick();
    chk("arm r0 we", {31'd0, RegWriteW}, 32'd1);

    // ARM PC write vs RV
    PCPlus4M = 32'h44;
    issue(1'b1, 1, 32'h100, 5'd15, 1'b1, 1'b1);
    tick();
    chk("arm pc",     {31'd0, PCSrcW}, 32'd1);
    chk("arm pc res", ResultW, 32'h100);
    issue(1'b0, 1, 32'h100, 5'd1, 1'b1, 1'b1);
    tick();
    chk("rv pc",     {31'd0, PCSrcW}, 32'd0);
    chk("rv pc res", ResultW, 32'h44);

    // Ext lanes and out-of-range select
    ExtResultM = {32'h0000CAFE, 32'h00001234};
    issue(1'b1, 4, 32'h77, 5'd3, 1'b1, 1'b0);
    tick();
    chk("ext lane1", ResultW, 32'h0000CAFE);
    issue(1'b1, 3, 32'h77, 5'd3, 1'b1, 1'b0);
    tick();
    chk("ext lane0", ResultW, 32'h00001234);
    issue(1'b1, 7, 32'h77, 5'd3, 1'b1, 1'b0);
    tick();
    chk("src7 alu", ResultW, 32'h77);
    idle_inputs();
    tick();

    // Stray data strobe in EMPTY is sticky
    ReadValidW = 1'b1;
    tick();
    ReadValidW = 1'b0;
    chk("perr set", {31'd0, ProtoErrW}, 32'd1);
    tick();
    chk("perr sticky", {31'd0, ProtoErrW}, 32'd1);

    // Reset during WAIT drops the load
    issue(1'b1, 0, 32'h0, 5'd4, 1'b1, 1'b0);
    tick();
    ValidM = 1'b0;
    chk("wait ready", {31'd0, ReadyW}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rstw ready", {31'd0, ReadyW},    32'd1);
    chk("rstw perr",  {31'd0, ProtoErrW}, 32'd0);
    tick();
    rst = 1'b1;
    ReadValidW = 1'b0;
    tick();
    chk("rstw nowrite", {31'd0, RegWriteW}, 32'd0);
    chk("rstw ready2",  {31'd0, ReadyW},    32'd1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (!rst) rst = 1'b1;
      else if ($urandom_range(0, 299) == 0) rst = 1'b0;
      ValidM     = ($urandom_range(0, 3) != 0);
      arm        = $urandom_range(0, 1) == 1;
      ResultSrcM = SRCW'($urandom_range(0, 7));
      ALUResultM = $urandom;
      PCPlus4M   = $urandom;
      ExtResultM = {$urandom, $urandom};
      RdM        = REGW'($urandom_range(0, 31));
      PCSrcM     = $urandom_range(0, 1) == 1;
      RegWriteM  = $urandom_range(0, 3) != 0;
      ReadDataW  = $urandom;
      ReadValidW = ($urandom_range(0, 9) < 3);
      tick();
    end
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
